seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter REFRESH_HZ, default 1000, full-frame refresh rate (all digits) in Hz.
REQ-003 Parameter NUM_DIGITS, default 4, digit count; legal range 1..8.
REQ-004 Parameter BLANK_CYCLES, default 24, anti-ghost blank clocks at start of each digit slot.
REQ-005 Parameter BRIGHT_BITS, default 4, brightness control width.
REQ-006 Parameter BLINK_FRAMES, default 250, frames per blink half-period.
REQ-007 Parameter SEG_ACTIVE_LOW, default 0, 1 = segment lines active-low.
REQ-008 Parameter DIG_ACTIVE_LOW, default 1, 1 = digit enables active-low.
REQ-009 clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-010 rst  input  1  asynchronous active-high reset.
REQ-011 enable  input  1  scan enable; 0 = display dark.
REQ-012 seg_data  input  8*NUM_DIGITS  active-high segment patterns, digit k at bits [8k+7:8k], bit 7 = DP.
REQ-013 blink_mask  input  NUM_DIGITS  per-digit blink enable.
REQ-014 brightness  input  BRIGHT_BITS  PWM duty code; 0 = dark, all-ones = full on-window.
REQ-015 seg  output  8  segment drive, polarity per SEG_ACTIVE_LOW.
REQ-016 seg_dig  output  NUM_DIGITS  digit enables, one-hot active, polarity per DIG_ACTIVE_LOW.
REQ-017 frame_done  output  1  one-clock pulse at end of each full frame.

Function
REQ-018 SLOT_LEN = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) clocks per digit slot; elaboration SHALL fail if SLOT_LEN <= BLANK_CYCLES+1 or NUM_DIGITS outside 1..8.
REQ-019 Single clock domain; slot counter sc 0..SLOT_LEN-1 and digit index di 0..NUM_DIGITS-1, di wraps to 0 after NUM_DIGITS-1 (non-power-of-2 counts legal).
REQ-020 seg_data slice for di SHALL be sampled at sc==0 and held for the slot.
REQ-021 brightness SHALL be latched at sc==0 of digit 0 only; mid-frame changes take effect next frame.
REQ-022 on_len = SLOT_LEN-BLANK_CYCLES when brightness all-ones, else ((SLOT_LEN-BLANK_CYCLES)*brightness)>>BRIGHT_BITS, computed at full width without overflow.
REQ-023 Digit di active iff BLANK_CYCLES <= sc < BLANK_CYCLES+on_len, not blinked-off, and enable=1; otherwise all digits and all segments inactive.
REQ-024 Blink phase toggles every BLINK_FRAMES frames, starting in visible phase after reset; digit k with blink_mask[k]=1 is dark during invisible phase.
REQ-025 seg and seg_dig SHALL be registered; outputs lag internal sc/di by exactly one clock.
REQ-026 frame_done SHALL pulse for one clock, registered, coincident with output of sc==SLOT_LEN-1 of digit NUM_DIGITS-1.
REQ-027 enable=0: counters, blink counter and phase held at reset values; outputs inactive from next clock; on enable=1 scan restarts at di=0, sc=0.
REQ-028 At most one digit active in any clock; never two digits active across a slot boundary (guaranteed by BLANK_CYCLES>=1).

Reset
REQ-029 rst asserted: sc=0, di=0, blink phase visible, blink counter 0, frame_done=0, seg all inactive (8'h00 if SEG_ACTIVE_LOW=0 else 8'hFF), seg_dig all inactive.
REQ-030 Reset mid-slot SHALL take effect asynchronously; first active digit after release is digit 0 after BLANK_CYCLES+1 clocks.

Structure
REQ-031 Shared package seg_pkg holds segment-bit index constants (A..G, DP), inactive-level constants and clog2 helper.
REQ-032 One sub-module seg_tick_gen: parameterised clock-enable divider producing the slot-boundary strobe; no derived clocks anywhere.

Verification (CLK_HZ=64000, REFRESH_HZ=1000, NUM_DIGITS=4, BLANK_CYCLES=2, BRIGHT_BITS=4, BLINK_FRAMES=2 -> SLOT_LEN=16)
REQ-033 Reset release, brightness=4'hF, seg_data=32'h06_5B_4F_66 -> digit0 active 14 clocks per slot with seg=8'h66 (polarity applied), digits cycle 0,1,2,3, frame_done every 64 clocks.
REQ-034 brightness=4'h8 -> each digit on exactly 7 clocks after 2 blank clocks; change to 4'h2 mid-frame -> 7 clocks until next frame, then 1 clock.
REQ-035 brightness=0 -> seg_dig never active; frame_done still pulses every 64 clocks.
REQ-036 blink_mask=4'b0010 -> digit1 dark in frames 2-3, 6-7, ...; other digits unaffected.
REQ-037 enable dropped at sc=9 of digit2 -> outputs inactive next clock; re-enable -> digit0 active after 3 clocks.
REQ-038 NUM_DIGITS=3, rst pulsed mid-slot -> outputs inactive immediately, di wraps 2->0, no two digits ever simultaneously active (assertion).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
package seg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [7:0] SEG_OFF_HIGH = 8'h00;
   localparam logic [7:0] SEG_OFF_LOW  = 8'hFF;

   typedef enum logic {
      PHASE_VISIBLE = 1'b0,
      PHASE_HIDDEN  = 1'b1
   } blink_phase_t;

   function automatic logic [7:0] seg_inactive(input bit active_low);
      return active_low ? SEG_OFF_LOW : SEG_OFF_HIGH;
   endfunction

   // Counter width helper that never returns zero, so 1- and 2-entry ranges still get a bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Control inputs and display drive outputs of the scan driver.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS  = 4,
   parameter int BRIGHT_BITS = 4
);
   logic                      enable;
   logic [8*NUM_DIGITS-1:0]   seg_data;
   logic [NUM_DIGITS-1:0]     blink_mask;
   logic [BRIGHT_BITS-1:0]    brightness;
   logic [7:0]                seg;
   logic [NUM_DIGITS-1:0]     seg_dig;
   logic                      frame_done;

   modport master (
      output enable, seg_data, blink_mask, brightness,
      input  seg, seg_dig, frame_done
   );

   modport slave (
      input  enable, seg_data, blink_mask, brightness,
      output seg, seg_dig, frame_done
   );
endinterface

// File: rtl/seg_scan_driver_tick_gen.sv
// Clock-enable divider: counts 0..PERIOD-1 while run is high and flags the last count.
module seg_tick_gen
   import seg_pkg::*;
#(
   parameter int PERIOD = 16,
   parameter int CNT_W  = clog2_min1(PERIOD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   assign last = (count == CNT_W'(PERIOD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!run || last) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with anti-ghost blanking, PWM brightness and per-digit blink.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int CLK_HZ         = 12_000_000,
   parameter int REFRESH_HZ     = 1000,
   parameter int NUM_DIGITS     = 4,
   parameter int BLANK_CYCLES   = 24,
   parameter int BRIGHT_BITS    = 4,
   parameter int BLINK_FRAMES   = 250,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input logic clk,
   input logic rst,
   seg_scan_driver_if.slave bus
);

   localparam int SLOT_LEN = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
   localparam int WIN      = SLOT_LEN - BLANK_CYCLES;
   localparam int SC_W     = clog2_min1(SLOT_LEN);
   localparam int DI_W     = clog2_min1(NUM_DIGITS);
   localparam int BF_W     = clog2_min1(BLINK_FRAMES);
   localparam int ON_W     = SC_W + BRIGHT_BITS;

   localparam logic [7:0]            SEG_OFF = seg_inactive(SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SLOT_LEN <= BLANK_CYCLES + 1) begin : g_bad_params
      $error("seg_scan_driver: NUM_DIGITS must be 1..8 and SLOT_LEN must exceed BLANK_CYCLES+1");
   end

   // On-window length; all-ones brightness maps to the whole window instead of losing the top fraction.
   function automatic logic [SC_W:0] calc_on_len(input logic [BRIGHT_BITS-1:0] b);
      logic [ON_W-1:0] prod;
      prod = ON_W'(WIN) * ON_W'(b);
      if (&b) begin
         return (SC_W+1)'(WIN);
      end
      return (SC_W+1)'(prod >> BRIGHT_BITS);
   endfunction

   logic [SC_W-1:0]        sc;
   logic                   slot_last;
   logic [DI_W-1:0]        di;
   logic                   frame_end;
   blink_phase_t           phase;
   logic [BF_W-1:0]        blink_cnt;
   logic [7:0]             seg_slot_p0;
   logic [BRIGHT_BITS-1:0] bright_p0;
   logic [SC_W:0]          sc_x;
   logic [SC_W:0]          on_len;
   logic                   in_window;
   logic                   blanked;
   logic                   digit_on;
   logic [NUM_DIGITS-1:0]  dig_onehot;
   logic [7:0]             seg_p1;
   logic [NUM_DIGITS-1:0]  seg_dig_p1;
   logic                   frame_done_p1;

   seg_tick_gen #(
      .PERIOD (SLOT_LEN),
      .CNT_W  (SC_W)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .run   (bus.enable),
      .count (sc),
      .last  (slot_last)
   );

   assign frame_end = bus.enable && slot_last && (di == DI_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         di <= '0;
      end else if (!bus.enable) begin
         di <= '0;
      end else if (slot_last) begin
         di <= (di == DI_W'(NUM_DIGITS - 1)) ? '0 : di + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase     <= PHASE_VISIBLE;
         blink_cnt <= '0;
      end else if (!bus.enable) begin
         phase     <= PHASE_VISIBLE;
         blink_cnt <= '0;
      end else if (frame_end) begin
         if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            phase     <= (phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Stage p0: slot data and frame brightness captured on the first clock of their slot/frame.
   always_ff @(posedge clk) begin
      if (bus.enable && sc == '0) begin
         seg_slot_p0 <= bus.seg_data[{di, 3'b000} +: 8];
         if (di == '0) begin
            bright_p0 <= bus.brightness;
         end
      end
   end

   assign sc_x       = {1'b0, sc};
   assign on_len     = calc_on_len(bright_p0);
   assign in_window  = (sc_x >= (SC_W+1)'(BLANK_CYCLES)) &&
                       (sc_x <  (SC_W+1)'(BLANK_CYCLES) + on_len);
   assign blanked    = bus.blink_mask[di] && (phase == PHASE_HIDDEN);
   assign digit_on   = bus.enable && in_window && !blanked;
   assign dig_onehot = NUM_DIGITS'(1) << di;

   // Stage p1: registered drive; XOR with the inactive level applies the line polarity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_p1        <= SEG_OFF;
         seg_dig_p1    <= DIG_OFF;
         frame_done_p1 <= 1'b0;
      end else begin
         frame_done_p1 <= frame_end;
         if (digit_on) begin
            seg_p1     <= seg_slot_p0 ^ SEG_OFF;
            seg_dig_p1 <= dig_onehot ^ DIG_OFF;
         end else begin
            seg_p1     <= SEG_OFF;
            seg_dig_p1 <= DIG_OFF;
         end
      end
   end

   assign bus.seg        = seg_p1;
   assign bus.seg_dig    = seg_dig_p1;
   assign bus.frame_done = frame_done_p1;

endmodule
